dram_port_arbiter: RTL and testbench

//  Shares one single-port, synchronous-read 4Kx32 data RAM between the two lanes
//  of the dual-issue MEM stage. Lane 1 (older instruction) has fixed priority.
//  A lane-2 access that collides with lane 1 is captured and replayed the next

---
 rtl/dram_port_arbiter_if.sv | 48 ++++
 rtl/dram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_port_arbiter_if.sv
// Lane and RAM bus bundle for dram_port_arbiter.
// slave = arbiter side, master = pipeline/RAM side.
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              CS1;
  logic              CS2;
  logic              R_W1;
  logic              R_W2;
  logic [31:0]       Addr1;
  logic [31:0]       Addr2;
  logic [DATA_W-1:0] Data1in;
  logic [DATA_W-1:0] Data2in;
  logic              STALL;
  logic [DATA_W-1:0] Data1out;
  logic [DATA_W-1:0] Data2out;
  logic              RVALID1;
  logic              RVALID2;
  logic              MISALIGN;
  logic [CNT_W-1:0]  STALL_CNT;
  logic              ram_cs;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  CS1, CS2, R_W1, R_W2,
    input  Addr1, Addr2, Data1in, Data2in,
    input  ram_rdata,
    output STALL, Data1out, Data2out,
    output RVALID1, RVALID2, MISALIGN,
    output STALL_CNT,
    output ram_cs, ram_rw, ram_addr, ram_wdata
  );

  modport master (
    output CS1, CS2, R_W1, R_W2,
    output Addr1, Addr2, Data1in, Data2in,
    output ram_rdata,
    input  STALL, Data1out, Data2out,
    input  RVALID1, RVALID2, MISALIGN,
    input  STALL_CNT,
    input  ram_cs, ram_rw, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Dual-lane arbiter for one single-port sync-read data RAM.
// Option: DRAM_ARB_FWD_EN forwards lane-1 store data to a same-word lane-2 load.
module dram_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic CLK,
  input  logic RST_N,
  dram_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, REPLAY2} state_t;

  state_t            state_q, state_d;
  logic              pend_rw_q;
  logic              pend_mis_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              rv1_q, rv2_q, fwd_q, mis_q;
  logic [DATA_W-1:0] d1_q, d2_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              mis1, mis2, fwd;
  logic [ADDR_W-1:0] wa1, wa2;
  logic              cs_c, rw_c, stall_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              cap, rd1, rd2, mis_c, fwd_go;
  logic              unused_addr_hi;

  assign mis1 = |bus.Addr1[1:0];
  assign mis2 = |bus.Addr2[1:0];
  assign wa1  = bus.Addr1[ADDR_W+1:2];
  assign wa2  = bus.Addr2[ADDR_W+1:2];
  assign unused_addr_hi = ^{bus.Addr1[31:ADDR_W+2],
                            bus.Addr2[31:ADDR_W+2]};

`ifdef DRAM_ARB_FWD_EN
  assign fwd = bus.CS1 & bus.CS2 & ~bus.R_W1 & bus.R_W2 &
               ~mis1 & ~mis2 & (wa1 == wa2);
`else
  assign fwd = 1'b0;
`endif

  // Next state, RAM drive and per-cycle access decode
  always_comb begin
    state_d = state_q;
    cs_c    = 1'b0;
    rw_c    = 1'b1;
    addr_c  = '0;
    wdata_c = '0;
    stall_c = 1'b0;
    cap     = 1'b0;
    rd1     = 1'b0;
    rd2     = 1'b0;
    mis_c   = 1'b0;
    fwd_go  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.CS1) begin
          mis_c = mis1;
          if (!mis1) begin
            cs_c    = 1'b1;
            rw_c    = bus.R_W1;
            addr_c  = wa1;
            wdata_c = bus.R_W1 ? '0 : bus.Data1in;
            rd1     = bus.R_W1;
          end
        end
        if (bus.CS2) begin
          if (fwd) begin
            fwd_go = 1'b1;
          end else if (bus.CS1) begin
            cap     = 1'b1;
            stall_c = 1'b1;
            state_d = REPLAY2;
          end else begin
            mis_c = mis2;
            if (!mis2) begin
              cs_c    = 1'b1;
              rw_c    = bus.R_W2;
              addr_c  = wa2;
              wdata_c = bus.R_W2 ? '0 : bus.Data2in;
              rd2     = bus.R_W2;
            end
          end
        end
      end
      REPLAY2: begin
        state_d = IDLE;
        mis_c   = pend_mis_q;
        if (!pend_mis_q) begin
          cs_c    = 1'b1;
          rw_c    = pend_rw_q;
          addr_c  = pend_addr_q;
          wdata_c = pend_rw_q ? '0 : pend_data_q;
          rd2     = pend_rw_q;
        end
      end
    endcase
    if (!RST_N) begin
      cs_c    = 1'b0;
      rw_c    = 1'b1;
      addr_c  = '0;
      wdata_c = '0;
      stall_c = 1'b0;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the colliding lane-2 access for replay
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_rw_q   <= 1'b0;
      pend_mis_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else if (cap) begin
      pend_rw_q   <= bus.R_W2;
      pend_mis_q  <= mis2;
      pend_addr_q <= wa2;
      pend_data_q <= bus.Data2in;
    end
  end

  // Read-return pulses and held read data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
      fwd_q <= 1'b0;
      mis_q <= 1'b0;
      d1_q  <= '0;
      d2_q  <= '0;
    end else begin
      rv1_q <= rd1;
      rv2_q <= rd2;
      fwd_q <= fwd_go;
      mis_q <= mis_c;
      if (rv1_q) d1_q <= bus.ram_rdata;
      if (fwd_go)     d2_q <= bus.Data1in;
      else if (rv2_q) d2_q <= bus.ram_rdata;
    end
  end

  // Saturating collision-stall counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 cnt_q <= '0;
    else if (cap && ~&cnt_q)    cnt_q <= cnt_q + 1'b1;
  end

  assign bus.STALL     = stall_c;
  assign bus.ram_cs    = cs_c;
  assign bus.ram_rw    = rw_c;
  assign bus.ram_addr  = addr_c;
  assign bus.ram_wdata = wdata_c;
  assign bus.Data1out  = rv1_q ? bus.ram_rdata : d1_q;
  assign bus.Data2out  = rv2_q ? bus.ram_rdata : d2_q;
  assign bus.RVALID1   = rv1_q;
  assign bus.RVALID2   = rv2_q | fwd_q;
  assign bus.MISALIGN  = mis_q;
  assign bus.STALL_CNT = cnt_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter.
// Transaction-level model of the shared RAM plus literal spot checks.
module tb_dram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef DRAM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  dram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();

  dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  logic [31:0] ram_mem [4096];
  always @(posedge CLK) begin
    if (bus.ram_cs) begin
      if (!bus.ram_rw) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else             bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  logic [31:0] m_mem [4096];
  bit          m_rep;
  bit          p_rw;
  logic [31:0] p_a, p_d;
  int          m_cnt;
  bit          e_stall, e_ramcs, e_rv1, e_rv2, e_mis;
  logic [31:0] e_d1, e_d2;
  int          e_cnt;
  bit          n_rv1, n_rv2, n_mis;
  logic [31:0] n_d1, n_d2;

  string       lit_name [64];
  int          lit_sel  [64];
  logic [31:0] lit_val  [64];
  int          lit_cnt = 0;
  int          lit_done = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic access(input int ln, input bit rw,
                        input logic [31:0] a, input logic [31:0] d);
    if (a[1:0] != 2'b00) begin
      n_mis = 1'b1;
    end else begin
      e_ramcs = 1'b1;
      if (!rw) m_mem[a[13:2]] = d;
      else if (ln == 1) begin n_rv1 = 1'b1; n_d1 = m_mem[a[13:2]]; end
      else begin n_rv2 = 1'b1; n_d2 = m_mem[a[13:2]]; end
    end
  endtask

  task automatic step(input bit c1, input bit r1, input logic [31:0] a1,
                      input logic [31:0] d1, input bit c2, input bit r2,
                      input logic [31:0] a2, input logic [31:0] d2);
    bit fw;
    e_rv1 = n_rv1; e_rv2 = n_rv2; e_mis = n_mis;
    if (n_rv1) e_d1 = n_d1;
    if (n_rv2) e_d2 = n_d2;
    e_cnt = m_cnt;
    n_rv1 = 0; n_rv2 = 0; n_mis = 0;
    e_ramcs = 0; e_stall = 0;
    if (m_rep) begin
      m_rep = 0;
      access(2, p_rw, p_a, p_d);
    end else begin
      fw = FWD && c1 && c2 && !r1 && r2 && a1[1:0] == 2'b00 &&
           a2[1:0] == 2'b00 && a1[13:2] == a2[13:2];
      if (c1) access(1, r1, a1, d1);
      if (c2) begin
        if (fw) begin
          n_rv2 = 1; n_d2 = d1;
        end else if (c1) begin
          e_stall = 1; m_rep = 1;
          p_rw = r2; p_a = a2; p_d = d2;
          if (m_cnt != CMAX) m_cnt++;
        end else begin
          access(2, r2, a2, d2);
        end
      end
    end
  endtask

  task automatic model_reset();
    m_rep = 0; m_cnt = 0; e_cnt = 0;
    e_stall = 0; e_ramcs = 0; e_rv1 = 0; e_rv2 = 0; e_mis = 0;
    e_d1 = 0; e_d2 = 0;
    n_rv1 = 0; n_rv2 = 0; n_mis = 0; n_d1 = 0; n_d2 = 0;
  endtask

  task automatic set_in(input bit c1, input bit r1, input logic [31:0] a1,
                        input logic [31:0] d1, input bit c2, input bit r2,
                        input logic [31:0] a2, input logic [31:0] d2);
    bus.CS1 = c1; bus.R_W1 = r1; bus.Addr1 = a1; bus.Data1in = d1;
    bus.CS2 = c2; bus.R_W2 = r2; bus.Addr2 = a2; bus.Data2in = d2;
  endtask

  task automatic cyc(input bit c1, input bit r1, input logic [31:0] a1,
                     input logic [31:0] d1, input bit c2, input bit r2,
                     input logic [31:0] a2, input logic [31:0] d2);
    @(posedge CLK); #1;
    set_in(c1, r1, a1, d1, c2, r2, a2, d2);
    step(c1, r1, a1, d1, c2, r2, a2, d2);
  endtask

  task automatic idle();
    cyc(0, 1, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic lit(input string nm, input int sel, input logic [31:0] v);
    lit_name[lit_cnt] = nm;
    lit_sel[lit_cnt]  = sel;
    lit_val[lit_cnt]  = v;
    lit_cnt++;
  endtask

  function automatic logic [31:0] sel_val(input int s);
    case (s)
      0: return bus.Data1out;
      1: return bus.Data2out;
      2: return 32'(bus.STALL_CNT);
      3: return {31'd0, bus.RVALID1};
      4: return {31'd0, bus.RVALID2};
      5: return {31'd0, bus.MISALIGN};
      6: return {31'd0, bus.STALL};
      default: return {31'd0, bus.ram_cs};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("STALL", {31'd0, bus.STALL}, {31'd0, e_stall});
    chk("ram_cs", {31'd0, bus.ram_cs}, {31'd0, e_ramcs});
    chk("RVALID1", {31'd0, bus.RVALID1}, {31'd0, e_rv1});
    chk("RVALID2", {31'd0, bus.RVALID2}, {31'd0, e_rv2});
    chk("MISALIGN", {31'd0, bus.MISALIGN}, {31'd0, e_mis});
    chk("STALL_CNT", 32'(bus.STALL_CNT), 32'(e_cnt));
    chk("Data1out", bus.Data1out, e_d1);
    chk("Data2out", bus.Data2out, e_d2);
    while (lit_done < lit_cnt) begin
      chk(lit_name[lit_done], sel_val(lit_sel[lit_done]),
          lit_val[lit_done]);
      lit_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 32'd0;
      m_mem[i]   = 32'd0;
    end
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    model_reset();
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    idle();
    lit("reset_cnt", 2, 32'd0);

    // single lane write then read
    cyc(1, 0, 32'h10, 32'hA5A5A5A5, 0, 1, 0, 0);
    cyc(1, 1, 32'h10, 0, 0, 1, 0, 0);
    lit("rd_stall", 6, 32'd0);
    idle();
    lit("rd1_data", 0, 32'hA5A5A5A5);
    lit("rd1_valid", 3, 32'd1);

    // lane-1 store and lane-2 load of the same word
    cyc(1, 0, 32'h20, 32'h11, 1, 1, 32'h20, 0);
    lit("coll_stall", 6, FWD ? 32'd0 : 32'd1);
    idle();
    if (FWD) begin
      lit("fwd_data", 1, 32'h11);
      lit("fwd_valid", 4, 32'd1);
      lit("fwd_cnt", 2, 32'd0);
    end
    idle();
    if (!FWD) begin
      lit("coll_data", 1, 32'h11);
      lit("coll_valid", 4, 32'd1);
      lit("coll_cnt", 2, 32'd1);
    end

    // lane 2 alone, then a replay with junk on the ignored inputs
    cyc(0, 1, 0, 0, 1, 0, 32'h40, 32'h5555);
    cyc(0, 1, 0, 0, 1, 1, 32'h40, 0);
    idle();
    lit("rd2_data", 1, 32'h5555);
    cyc(1, 1, 32'h10, 0, 1, 0, 32'h30, 32'h77);
    cyc(1, 0, 32'h10, 32'hDEAD, 1, 0, 32'h30, 32'hBEEF);
    cyc(0, 1, 0, 0, 1, 1, 32'h30, 0);
    idle();
    lit("replay_wr", 1, 32'h77);
    cyc(1, 1, 32'h10, 0, 0, 1, 0, 0);
    idle();
    lit("ignored_wr", 0, 32'hA5A5A5A5);

    // reset during replay, lane inputs kept active
    cyc(1, 1, 32'h20, 0, 1, 1, 32'h10, 0);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    model_reset();
    lit("rst_ramcs", 7, 32'd0);
    lit("rst_stall", 6, 32'd0);
    lit("rst_d1", 0, 32'd0);
    @(posedge CLK); #1;
    set_in(0, 1, 0, 0, 1, 1, 32'h10, 0);
    RST_N = 1'b1;
    step(0, 1, 0, 0, 1, 1, 32'h10, 0);
    lit("post_rst_stall", 6, 32'd0);
    idle();
    lit("post_rst_d2", 1, 32'hA5A5A5A5);
    lit("post_rst_v2", 4, 32'd1);

    // address wrap and misalignment
    cyc(1, 0, 32'h4, 32'hCAFEF00D, 0, 1, 0, 0);
    cyc(1, 1, 32'h4004, 0, 0, 1, 0, 0);
    idle();
    lit("wrap_data", 0, 32'hCAFEF00D);
    cyc(1, 1, 32'h13, 0, 0, 1, 0, 0);
    lit("mis_ramcs", 7, 32'd0);
    idle();
    lit("mis_pulse", 5, 32'd1);
    lit("mis_hold", 0, 32'hCAFEF00D);
    idle();
    lit("mis_once", 5, 32'd0);
    cyc(1, 0, 32'h8, 32'h3, 1, 1, 32'h22, 0);
    idle();
    idle();

    // saturate the stall counter
    for (int i = 0; i < CMAX + 4; i++) begin
      cyc(1, 1, 32'h10, 0, 1, 1, 32'h14, 0);
      idle();
    end
    idle();
    lit("sat_cnt", 2, 32'(CMAX));
    idle();

    @(negedge CLK); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
